// File: rtl/sb_rdi_pkg.sv
// ----------------------------------------------------------------------------
// sb_rdi_pkg
// Shared constants for the sideband RDI encoder/decoder pair: packet opcodes,
// the RDI source id and message codes, the RDI message subcodes and the state
// type of the RX decoder FSM.
// ----------------------------------------------------------------------------
package sb_rdi_pkg;

    // Sideband opcodes (hdr[4:0])
    localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
    localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

    // RDI message identification
    localparam logic [2:0] RDI_SRCID       = 3'b011;
    localparam logic [7:0] MSGCODE_RDI_REQ = 8'h01;
    localparam logic [7:0] MSGCODE_RDI_RSP = 8'h02;

    // RDI message subcodes (hdr[39:32])
    localparam logic [7:0] SUB_ACTIVE     = 8'h01;
    localparam logic [7:0] SUB_PMNAK      = 8'h02;
    localparam logic [7:0] SUB_L1         = 8'h04;
    localparam logic [7:0] SUB_L2         = 8'h08;
    localparam logic [7:0] SUB_LINK_RESET = 8'h09;
    localparam logic [7:0] SUB_LINK_ERROR = 8'h0A;
    localparam logic [7:0] SUB_RETRAIN    = 8'h0B;
    localparam logic [7:0] SUB_DISABLE    = 8'h0C;

    // RX decoder states; explicit encodings keep the legacy numbering stable
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DECODE    = 4'd1,
        ST_WAIT_DATA = 4'd2,
        ST_HOLD      = 4'd3,
        ST_FWD0      = 4'd4,
        ST_FWD1      = 4'd5,
        ST_FWD2      = 4'd6,
        ST_FWD3      = 4'd7,
        ST_RDI_OUT   = 4'd8,
        ST_ERROR     = 4'd9
    } state_t;

endpackage

// File: rtl/sb_rdi_msg_map.sv
// ----------------------------------------------------------------------------
// sb_rdi_msg_map
// Combinational map from an RDI subcode plus request/response flag to the
// 4-bit RDI message number used by the RDI FSM. Shared with the encoder's
// inverse table so both directions agree on the numbering.
//
// Ports:
//   subcode : in  [7:0] RDI message subcode
//   is_rsp  : in        1 = response message, 0 = request message
//   msg_no  : out [3:0] message number (0 when no hit)
//   hit     : out       subcode is defined for the given direction
// ----------------------------------------------------------------------------
module sb_rdi_msg_map
    import sb_rdi_pkg::*;
(
    input  logic [7:0] subcode,
    input  logic       is_rsp,
    output logic [3:0] msg_no,
    output logic       hit
);

    // Requests occupy numbers 1..7, responses 8..15. PMNAK only exists as a
    // response, so a request carrying it is reported as a miss.
    always_comb begin
        msg_no = 4'd0;
        hit    = 1'b1;
        if (!is_rsp) begin
            case (subcode)
                SUB_ACTIVE:     msg_no = 4'd1;
                SUB_L1:         msg_no = 4'd2;
                SUB_L2:         msg_no = 4'd3;
                SUB_LINK_RESET: msg_no = 4'd4;
                SUB_LINK_ERROR: msg_no = 4'd5;
                SUB_RETRAIN:    msg_no = 4'd6;
                SUB_DISABLE:    msg_no = 4'd7;
                default:        hit    = 1'b0;
            endcase
        end else begin
            case (subcode)
                SUB_ACTIVE:     msg_no = 4'd8;
                SUB_PMNAK:      msg_no = 4'd9;
                SUB_L1:         msg_no = 4'd10;
                SUB_L2:         msg_no = 4'd11;
                SUB_LINK_RESET: msg_no = 4'd12;
                SUB_LINK_ERROR: msg_no = 4'd13;
                SUB_RETRAIN:    msg_no = 4'd14;
                SUB_DISABLE:    msg_no = 4'd15;
                default:        hit    = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/sb_rdi_decoder.sv
// ----------------------------------------------------------------------------
// sb_rdi_decoder
// Sideband RX decoder at the RDI boundary. Pops packets from a
// first-word-fall-through RX FIFO, sends LinkMgmt.RDI request/response
// messages to the RDI FSM as a message number, forwards every other valid
// message to the adapter as 32-bit pl_cfg phases (gated by adapter credit
// and wake state) and drops anything it cannot classify.
//
// Optional feature: define SB_RX_PARITY_CHECK_EN to check CP/DP parity and
// drop packets that fail; otherwise parity bits are forwarded unchanged.
//
// Ports:
//   i_clk                    : in        RDI-domain clock
//   i_rst_n                  : in        synchronous active-low reset
//   i_fifo_data              : in  [63:0] RX FIFO head word
//   i_fifo_empty             : in        RX FIFO empty
//   o_fifo_read_en           : out       pop the head word (combinational)
//   i_adapter_is_full        : in        no adapter credit available
//   i_adapter_is_waked_up    : in        adapter sideband is awake
//   o_wake_adapter           : out       request adapter wake
//   o_pl_cfg                 : out [31:0] phase forwarded to the adapter
//   o_pl_cfg_vld             : out       o_pl_cfg valid
//   o_rising_edge_pl_cfg_vld : out       pulse at the first phase of a packet
//   o_msg_no                 : out [3:0] decoded RDI message number
//   o_msg_valid              : out       strobe qualifying o_msg_no
//   o_rx_error               : out       pulse when a packet is dropped
// ----------------------------------------------------------------------------
module sb_rdi_decoder
    import sb_rdi_pkg::*;
#(
    parameter int W_PKT = 64,
    parameter int W_CFG = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [W_PKT-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_read_en,
    input  logic             i_adapter_is_full,
    input  logic             i_adapter_is_waked_up,
    output logic             o_wake_adapter,
    output logic [W_CFG-1:0] o_pl_cfg,
    output logic             o_pl_cfg_vld,
    output logic             o_rising_edge_pl_cfg_vld,
    output logic [3:0]       o_msg_no,
    output logic             o_msg_valid,
    output logic             o_rx_error
);

    state_t           state;
    state_t           state_d;
    logic [W_PKT-1:0] hdr_q;
    logic [W_PKT-1:0] data_q;
    logic             read_en;

    logic [4:0] opcode;
    logic [7:0] msgcode;
    logic [2:0] srcid;
    logic [7:0] msgsubcode;
    logic       gate_ok;
    logic       is_rdi;
    logic       is_data_pkt;
    logic [3:0] map_no;
    logic       map_hit;
    logic       hdr_par_err;
    logic       data_par_err;

    assign opcode      = hdr_q[4:0];
    assign msgcode     = hdr_q[21:14];
    assign srcid       = hdr_q[31:29];
    assign msgsubcode  = hdr_q[39:32];
    assign gate_ok     = !i_adapter_is_full && i_adapter_is_waked_up;
    assign is_data_pkt = (opcode == OPC_MSG_DATA);
    assign is_rdi      = (opcode == OPC_MSG_NODATA) && (srcid == RDI_SRCID) &&
                         ((msgcode == MSGCODE_RDI_REQ) || (msgcode == MSGCODE_RDI_RSP));

    sb_rdi_msg_map u_msg_map (
        .subcode (msgsubcode),
        .is_rsp  (msgcode == MSGCODE_RDI_RSP),
        .msg_no  (map_no),
        .hit     (map_hit)
    );

`ifdef SB_RX_PARITY_CHECK_EN
    // CP covers hdr[61:0]. DP covers the data word of a DATA packet and must
    // be clear on a NODATA packet. The data check looks at the FIFO head
    // because it is evaluated in the same cycle the data word is popped.
    assign hdr_par_err  = (hdr_q[62] != ^hdr_q[61:0]) ||
                          ((opcode == OPC_MSG_NODATA) && hdr_q[63]);
    assign data_par_err = (hdr_q[63] != ^i_fifo_data);
`else
    assign hdr_par_err  = 1'b0;
    assign data_par_err = 1'b0;
`endif

    // Next-state and pop logic. A pop is only issued in IDLE (header) and
    // WAIT_DATA (data word), and never while reset is held, so no FIFO entry
    // is consumed without being captured.
    always_comb begin
        state_d = state;
        read_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!i_fifo_empty) begin
                    read_en = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (hdr_par_err)                  state_d = ST_ERROR;
                else if (is_rdi)                  state_d = map_hit ? ST_RDI_OUT : ST_ERROR;
                else if (is_data_pkt)             state_d = ST_WAIT_DATA;
                else if (opcode == OPC_MSG_NODATA) state_d = gate_ok ? ST_FWD0 : ST_HOLD;
                else                              state_d = ST_ERROR;
            end
            ST_WAIT_DATA: begin
                if (!i_fifo_empty) begin
                    read_en = 1'b1;
                    if (data_par_err) state_d = ST_ERROR;
                    else              state_d = gate_ok ? ST_FWD0 : ST_HOLD;
                end
            end
            ST_HOLD:    if (gate_ok) state_d = ST_FWD0;
            ST_FWD0:    state_d = ST_FWD1;
            ST_FWD1:    state_d = is_data_pkt ? ST_FWD2 : ST_IDLE;
            ST_FWD2:    state_d = ST_FWD3;
            ST_FWD3:    state_d = ST_IDLE;
            ST_RDI_OUT: state_d = ST_IDLE;
            ST_ERROR:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign o_fifo_read_en = read_en && i_rst_n;

    // State, capture registers and outputs. Outputs are registered from the
    // next state so that each one is a clean flop that lines up exactly with
    // the state it belongs to (e.g. o_msg_valid is high while in RDI_OUT).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                    <= ST_IDLE;
            hdr_q                    <= '0;
            data_q                   <= '0;
            o_wake_adapter           <= 1'b0;
            o_pl_cfg                 <= '0;
            o_pl_cfg_vld             <= 1'b0;
            o_rising_edge_pl_cfg_vld <= 1'b0;
            o_msg_no                 <= 4'd0;
            o_msg_valid              <= 1'b0;
            o_rx_error               <= 1'b0;
        end else begin
            state <= state_d;
            if ((state == ST_IDLE) && read_en)      hdr_q  <= i_fifo_data;
            if ((state == ST_WAIT_DATA) && read_en) data_q <= i_fifo_data;

            o_pl_cfg_vld             <= state_d inside {ST_FWD0, ST_FWD1, ST_FWD2, ST_FWD3};
            o_rising_edge_pl_cfg_vld <= (state_d == ST_FWD0);
            o_wake_adapter           <= (state_d == ST_HOLD) && !i_adapter_is_waked_up;
            o_msg_valid              <= (state_d == ST_RDI_OUT);
            o_msg_no                 <= (state_d == ST_RDI_OUT) ? map_no : 4'd0;
            o_rx_error               <= (state_d == ST_ERROR);

            case (state_d)
                ST_FWD0: o_pl_cfg <= hdr_q[W_CFG-1:0];
                ST_FWD1: o_pl_cfg <= hdr_q[W_PKT-1:W_CFG];
                ST_FWD2: o_pl_cfg <= data_q[W_CFG-1:0];
                ST_FWD3: o_pl_cfg <= data_q[W_PKT-1:W_CFG];
                default: o_pl_cfg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_rdi_decoder.sv
// ----------------------------------------------------------------------------
// tb_sb_rdi_decoder
// Self-checking bench for sb_rdi_decoder. A queue models the FWFT RX FIFO;
// tests push packets and the outputs they should produce, and a negedge
// monitor pops and compares those expectations as the decoder responds.
// Build with SB_RX_PARITY_CHECK_EN defined to exercise the parity drop.
// ----------------------------------------------------------------------------
module tb_sb_rdi_decoder;

    localparam logic [4:0] OPC_NODATA = 5'b10010;
    localparam logic [4:0] OPC_DATA   = 5'b11011;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] i_fifo_data = '0;
    logic        i_fifo_empty = 1'b1;
    logic        o_fifo_read_en;
    logic        i_adapter_is_full = 1'b0;
    logic        i_adapter_is_waked_up = 1'b1;
    logic        o_wake_adapter;
    logic [31:0] o_pl_cfg;
    logic        o_pl_cfg_vld;
    logic        o_rising_edge_pl_cfg_vld;
    logic [3:0]  o_msg_no;
    logic        o_msg_valid;
    logic        o_rx_error;

    sb_rdi_decoder #(.W_PKT(64), .W_CFG(32)) dut (
        .i_clk                    (i_clk),
        .i_rst_n                  (i_rst_n),
        .i_fifo_data              (i_fifo_data),
        .i_fifo_empty             (i_fifo_empty),
        .o_fifo_read_en           (o_fifo_read_en),
        .i_adapter_is_full        (i_adapter_is_full),
        .i_adapter_is_waked_up    (i_adapter_is_waked_up),
        .o_wake_adapter           (o_wake_adapter),
        .o_pl_cfg                 (o_pl_cfg),
        .o_pl_cfg_vld             (o_pl_cfg_vld),
        .o_rising_edge_pl_cfg_vld (o_rising_edge_pl_cfg_vld),
        .o_msg_no                 (o_msg_no),
        .o_msg_valid              (o_msg_valid),
        .o_rx_error               (o_rx_error)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard state
    logic [63:0] fifo_q[$];
    logic [31:0] exp_cfg[$];
    logic [3:0]  exp_msg[$];
    int          exp_len[$];
    int          exp_err = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rd_cyc = -1;
    int          msg_cyc = -1;
    int          first_vld_cyc = -1;
    int          rise_cnt = 0;
    int          run_len = 0;
    bit          prev_vld = 1'b0;
    bit          will_pop = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Builds a header with correct CP/DP so it is accepted with or without
    // parity checking enabled.
    function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic [2:0] src,
                                           input logic [7:0] mc, input logic [7:0] sub,
                                           input logic [63:0] data, input logic is_data);
        logic [63:0] h;
        h        = '0;
        h[4:0]   = opc;
        h[21:14] = mc;
        h[31:29] = src;
        h[39:32] = sub;
        h[62]    = ^h[61:0];
        h[63]    = is_data ? ^data : 1'b0;
        return h;
    endfunction

    // Monitor plus FIFO model. Outputs are compared at the falling edge; the
    // FIFO then retires the word popped at the previous rising edge, presents
    // the new head, and records whether the decoder will pop it.
    always @(negedge i_clk) begin
        logic [31:0] ev;
        logic [3:0]  em;
        int          el;
        if (mon_en) begin
            if (o_pl_cfg_vld) begin
                checks++;
                if (exp_cfg.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cfg_unexpected: vld with o_pl_cfg=%h, required no phase", o_pl_cfg);
                end else begin
                    ev = exp_cfg.pop_front();
                    if (o_pl_cfg !== ev) begin
                        errors++;
                        $display("[TB] FAIL cfg_value: got %h, required %h", o_pl_cfg, ev);
                    end
                end
                if (!prev_vld) first_vld_cyc = cyc;
                run_len++;
            end else if (prev_vld) begin
                checks++;
                el = (exp_len.size() != 0) ? exp_len.pop_front() : -1;
                if (run_len != el) begin
                    errors++;
                    $display("[TB] FAIL cfg_run_length: got %0d phases, required %0d", run_len, el);
                end
                run_len = 0;
            end
            checks++;
            if (o_rising_edge_pl_cfg_vld !== (o_pl_cfg_vld && !prev_vld)) begin
                errors++;
                $display("[TB] FAIL rising_edge: got %b, required %b", o_rising_edge_pl_cfg_vld,
                         o_pl_cfg_vld && !prev_vld);
            end
            if (o_rising_edge_pl_cfg_vld) rise_cnt++;
            if (o_msg_valid) begin
                msg_cyc = cyc;
                checks++;
                if (exp_msg.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL msg_unexpected: o_msg_no=%0d, required no message", o_msg_no);
                end else begin
                    em = exp_msg.pop_front();
                    if (o_msg_no !== em) begin
                        errors++;
                        $display("[TB] FAIL msg_no: got %0d, required %0d", o_msg_no, em);
                    end
                end
            end
            if (o_rx_error) begin
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("[TB] FAIL rx_error_unexpected: got 1, required 0");
                end else begin
                    exp_err--;
                end
            end
        end
        prev_vld = o_pl_cfg_vld;
        if (will_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
        #1;
        will_pop = (o_fifo_read_en === 1'b1);
        if (will_pop) last_rd_cyc = cyc;
    end

    // Waits (bounded) until every pushed word and expectation is consumed.
    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_cfg.size() != 0 || exp_msg.size() != 0 || exp_err != 0 ||
                fifo_q.size() != 0 || o_pl_cfg_vld) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic flush_expectations();
        exp_cfg.delete();
        exp_msg.delete();
        exp_len.delete();
        exp_err = 0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_fifo_read_en, o_wake_adapter, o_pl_cfg, o_pl_cfg_vld, o_rising_edge_pl_cfg_vld,
             o_msg_no, o_msg_valid, o_rx_error} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got vld=%b cfg=%h msg=%b/%0d err=%b wake=%b rd=%b, required all 0",
                     o_pl_cfg_vld, o_pl_cfg, o_msg_valid, o_msg_no, o_rx_error, o_wake_adapter, o_fifo_read_en);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_rdi_request();
        msg_cyc = -1;
        fifo_q.push_back(mk_hdr(OPC_NODATA, 3'b011, 8'h01, 8'h04, 64'd0, 1'b0));
        exp_msg.push_back(4'd2);
        wait_quiet();
        checks++;
        if (exp_msg.size() != 0) begin
            errors++;
            $display("[TB] FAIL rdi_req_missing: %0d messages pending, required 0", exp_msg.size());
        end
        checks++;
        if (msg_cyc - last_rd_cyc != 2) begin
            errors++;
            $display("[TB] FAIL rdi_req_latency: got %0d cycles after read_en, required 2", msg_cyc - last_rd_cyc);
        end
        flush_expectations();
    endtask

    task automatic test_rdi_response();
        fifo_q.push_back(mk_hdr(OPC_NODATA, 3'b011, 8'h02, 8'h02, 64'd0, 1'b0));
        exp_msg.push_back(4'd9);
        fifo_q.push_back(mk_hdr(OPC_NODATA, 3'b011, 8'h02, 8'h05, 64'd0, 1'b0));
        exp_err++;
        wait_quiet();
        checks++;
        if (exp_msg.size() != 0 || exp_err != 0) begin
            errors++;
            $display("[TB] FAIL rdi_rsp_missing: %0d messages, %0d errors pending, required 0", exp_msg.size(), exp_err);
        end
        flush_expectations();
    endtask

    // All fifteen mapped codes pushed back to back.
    task automatic test_back_to_back_rdi();
        logic [7:0] subs [15];
        subs = '{8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                 8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 15; i++) begin
            fifo_q.push_back(mk_hdr(OPC_NODATA, 3'b011, (i < 7) ? 8'h01 : 8'h02, subs[i], 64'd0, 1'b0));
            exp_msg.push_back(4'(i + 1));
        end
        wait_quiet();
        checks++;
        if (exp_msg.size() != 0) begin
            errors++;
            $display("[TB] FAIL rdi_map_missing: %0d messages pending, required 0", exp_msg.size());
        end
        flush_expectations();
    endtask

    task automatic test_nodata_forward();
        int r0;
        r0 = rise_cnt;
        fifo_q.push_back(64'h00000000_00404012);
        exp_cfg.push_back(32'h00404012);
        exp_cfg.push_back(32'h00000000);
        exp_len.push_back(2);
        wait_quiet();
        checks++;
        if (exp_cfg.size() != 0 || rise_cnt - r0 != 1) begin
            errors++;
            $display("[TB] FAIL nodata_forward: %0d phases pending, %0d rising pulses, required 0 and 1",
                     exp_cfg.size(), rise_cnt - r0);
        end
        flush_expectations();
    endtask

    task automatic test_data_late();
        logic [63:0] d;
        logic [63:0] h;
        int          n;
        int          r0;
        r0 = rise_cnt;
        d  = 64'hCAFEBABE_DEADBEEF;
        h  = mk_hdr(OPC_DATA, 3'b001, 8'h10, 8'h00, d, 1'b1);
        fifo_q.push_back(h);
        n = 0;
        while (fifo_q.size() != 0 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (fifo_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL data_hdr_pop: header still queued, required popped");
        end
        repeat (5) @(negedge i_clk);
        fifo_q.push_back(d);
        exp_cfg.push_back(h[31:0]);
        exp_cfg.push_back(h[63:32]);
        exp_cfg.push_back(32'hDEADBEEF);
        exp_cfg.push_back(32'hCAFEBABE);
        exp_len.push_back(4);
        wait_quiet();
        checks++;
        if (exp_cfg.size() != 0 || rise_cnt - r0 != 1) begin
            errors++;
            $display("[TB] FAIL data_forward: %0d phases pending, %0d rising pulses, required 0 and 1",
                     exp_cfg.size(), rise_cnt - r0);
        end
        flush_expectations();
    endtask

    task automatic test_backpressure();
        logic [63:0] h;
        int          rel;
        int          n;
        h = mk_hdr(OPC_NODATA, 3'b010, 8'h20, 8'h33, 64'd0, 1'b0);
        i_adapter_is_full = 1'b1;
        first_vld_cyc = -1;
        fifo_q.push_back(h);
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_wake_adapter !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_wake: got %b while awake, required 0", o_wake_adapter);
        end
        exp_cfg.push_back(h[31:0]);
        exp_cfg.push_back(h[63:32]);
        exp_len.push_back(2);
        rel = cyc;
        i_adapter_is_full = 1'b0;
        n = 0;
        while (first_vld_cyc == -1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (first_vld_cyc != rel + 1) begin
            errors++;
            $display("[TB] FAIL bp_release: first vld at cycle %0d, required %0d", first_vld_cyc, rel + 1);
        end
        wait_quiet();
        checks++;
        if (exp_cfg.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_missing: %0d phases pending, required 0", exp_cfg.size());
        end
        flush_expectations();
    endtask

    task automatic test_wake();
        logic [63:0] h;
        h = mk_hdr(OPC_NODATA, 3'b000, 8'h44, 8'h01, 64'd0, 1'b0);
        i_adapter_is_waked_up = 1'b0;
        fifo_q.push_back(h);
        repeat (6) @(negedge i_clk);
        checks++;
        if (o_wake_adapter !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wake_asserted: got %b, required 1", o_wake_adapter);
        end
        exp_cfg.push_back(h[31:0]);
        exp_cfg.push_back(h[63:32]);
        exp_len.push_back(2);
        i_adapter_is_waked_up = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_wake_adapter !== 1'b0 || o_pl_cfg_vld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wake_release: got wake=%b vld=%b, required wake=0 vld=1", o_wake_adapter, o_pl_cfg_vld);
        end
        wait_quiet();
        checks++;
        if (exp_cfg.size() != 0) begin
            errors++;
            $display("[TB] FAIL wake_missing: %0d phases pending, required 0", exp_cfg.size());
        end
        flush_expectations();
    endtask

    task automatic test_bad_opcode();
        fifo_q.push_back(mk_hdr(5'b11111, 3'b011, 8'h01, 8'h01, 64'd0, 1'b0));
        exp_err++;
        wait_quiet();
        checks++;
        if (exp_err != 0) begin
            errors++;
            $display("[TB] FAIL bad_opcode: %0d drops pending, required 0", exp_err);
        end
        flush_expectations();
    endtask

    task automatic test_reset_mid_packet();
        logic [63:0] d;
        int          n;
        int          ph;
        d = 64'h01234567_89ABCDEF;
        mon_en = 1'b0;
        fifo_q.push_back(mk_hdr(OPC_DATA, 3'b001, 8'h10, 8'h00, d, 1'b1));
        fifo_q.push_back(d);
        n  = 0;
        ph = 0;
        while (ph < 3 && n < 40) begin
            @(negedge i_clk);
            n++;
            if (o_pl_cfg_vld) ph++;
        end
        checks++;
        if (ph != 3 || o_pl_cfg !== 32'h89ABCDEF) begin
            errors++;
            $display("[TB] FAIL reset_mid_fwd2: reached phase %0d with %h, required phase 3 with 89abcdef", ph, o_pl_cfg);
        end
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_fifo_read_en, o_wake_adapter, o_pl_cfg, o_pl_cfg_vld, o_rising_edge_pl_cfg_vld,
             o_msg_no, o_msg_valid, o_rx_error} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got vld=%b cfg=%h msg=%b err=%b, required all 0",
                     o_pl_cfg_vld, o_pl_cfg, o_msg_valid, o_rx_error);
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_pl_cfg_vld !== 1'b0 || o_fifo_read_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got vld=%b read_en=%b, required 0 0", o_pl_cfg_vld, o_fifo_read_en);
        end
        fifo_q.delete();
        flush_expectations();
        run_len = 0;
        mon_en  = 1'b1;
    endtask

    task automatic test_parity();
        logic [63:0] h;
        h     = mk_hdr(OPC_NODATA, 3'b000, 8'h05, 8'h00, 64'd0, 1'b0);
        h[62] = ~h[62];
        fifo_q.push_back(h);
`ifdef SB_RX_PARITY_CHECK_EN
        exp_err++;
`else
        exp_cfg.push_back(h[31:0]);
        exp_cfg.push_back(h[63:32]);
        exp_len.push_back(2);
`endif
        wait_quiet();
        checks++;
        if (exp_err != 0 || exp_cfg.size() != 0) begin
            errors++;
            $display("[TB] FAIL parity_cp: %0d drops, %0d phases pending, required 0", exp_err, exp_cfg.size());
        end
        flush_expectations();
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_rdi_request();
        test_rdi_response();
        test_back_to_back_rdi();
        test_nodata_forward();
        test_data_late();
        test_backpressure();
        test_wake();
        test_bad_opcode();
        test_reset_mid_packet();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
